// File: rtl/fetch_unit_if.sv
// Memory read port, decode queue and redirect signals of the fetch unit.
// The master modport is the fetch unit; the slave side is memory plus decode.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 16
) ();
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_enable;
  logic                  mem_wr;
  logic [15:0]           mem_data_in;
  logic [15:0]           mem_data_out;
  logic                  instr_valid;
  logic [15:0]           instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_ready;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  halted;

  modport master (
    output mem_addr, mem_enable, mem_wr, mem_data_in,
    output instr_valid, instr, instr_pc, halted,
    input  mem_data_out, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_addr, mem_enable, mem_wr, mem_data_in,
    input  instr_valid, instr, instr_pc, halted,
    output mem_data_out, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, zero-latency memory read and a small {instr, pc} FIFO.
// Optional FETCH_PERF_EN adds saturating fetch_count / stall_count ports.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000
) (
  input  logic           clk,
  input  logic           rst,
`ifdef FETCH_PERF_EN
  output logic [15:0]    fetch_count,
  output logic [15:0]    stall_count,
`endif
  fetch_unit_if.master   bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshake: a queue entry transfers on any edge where instr_valid and
  // instr_ready are both high; instr_valid never depends on instr_ready.
  logic [ADDR_WIDTH-1:0] pc;
  logic [15:0]           q_instr [DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc    [DEPTH];
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count;
  logic                  halted_q;
  logic                  pop, issue, is_hlt;
  logic                  unused_redirect_lsb;

  assign unused_redirect_lsb = bus.redirect_pc[0];

  assign pop    = bus.instr_valid & bus.instr_ready;
  assign issue  = !rst & !halted_q & !bus.redirect_valid & ((count < DEPTH_C) | pop);
  assign is_hlt = (bus.mem_data_out[15:12] == 4'hF);

  assign bus.mem_addr    = pc;
  assign bus.mem_enable  = issue;
  assign bus.mem_wr      = 1'b0;
  assign bus.mem_data_in = 16'h0000;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = q_instr[head];
  assign bus.instr_pc    = q_pc[head];
  assign bus.halted      = halted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      halted_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      // Redirect wins over everything: drop the queue and restart at the target.
      pc       <= {bus.redirect_pc[ADDR_WIDTH-1:1], 1'b0};
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      halted_q <= 1'b0;
    end else begin
      if (issue) begin
        q_instr[tail] <= bus.mem_data_out;
        q_pc[tail]    <= pc;
        tail          <= tail + PW'(1);
        pc            <= pc + ADDR_WIDTH'(2);
        if (is_hlt) halted_q <= 1'b1;
      end
      if (pop) head <= head + PW'(1);
      case ({issue, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic stall;
  assign stall = !rst & !halted_q & !bus.redirect_valid & !issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (issue && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: instance a (RESET_PC 0) and instance b (RESET_PC FFFC)
// share one behavioural single-cycle memory.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   issues;

  logic [15:0] mem [0:63];

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(16)) bus_a ();
  fetch_unit_if #(.ADDR_WIDTH(16)) bus_b ();

  assign bus_a.mem_data_out = mem[bus_a.mem_addr[6:1]];
  assign bus_b.mem_data_out = mem[bus_b.mem_addr[6:1]];

`ifdef FETCH_PERF_EN
  logic [15:0] fc_a, sc_a, fc_b, sc_b;
`endif

  fetch_unit #(.ADDR_WIDTH(16), .DEPTH(2), .RESET_PC(16'h0000)) dut_a (
    .clk(clk),
    .rst(rst),
`ifdef FETCH_PERF_EN
    .fetch_count(fc_a),
    .stall_count(sc_a),
`endif
    .bus(bus_a)
  );

  fetch_unit #(.ADDR_WIDTH(16), .DEPTH(2), .RESET_PC(16'hFFFC)) dut_b (
    .clk(clk),
    .rst(rst),
`ifdef FETCH_PERF_EN
    .fetch_count(fc_b),
    .stall_count(sc_b),
`endif
    .bus(bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0]  = 16'h1234;
    mem[1]  = 16'h5678;
    mem[2]  = 16'hF000;
    mem[32] = 16'h2222;
    mem[33] = 16'h3333;

    bus_a.instr_ready    = 1'b1;
    bus_a.redirect_valid = 1'b0;
    bus_a.redirect_pc    = 16'h0000;
    bus_b.instr_ready    = 1'b1;
    bus_b.redirect_valid = 1'b0;
    bus_b.redirect_pc    = 16'h0000;

    // Reset state and stream 1234/5678/F000 with continuous ready.
    rst = 1'b1;
    step();
    step();
    check("rst_mem_enable", 32'(bus_a.mem_enable), 32'd0);
    check("rst_valid", 32'(bus_a.instr_valid), 32'd0);
    check("rst_halted", 32'(bus_a.halted), 32'd0);
    check("rst_mem_wr", 32'(bus_a.mem_wr), 32'd0);
    check("rst_mem_data_in", 32'(bus_a.mem_data_in), 32'd0);
    rst = 1'b0;
    #1;
    check("c0_valid", 32'(bus_a.instr_valid), 32'd0);
    check("c0_mem_enable", 32'(bus_a.mem_enable), 32'd1);
    check("c0_mem_addr", 32'(bus_a.mem_addr), 32'h0000);
    check("b_c0_addr", 32'(bus_b.mem_addr), 32'hFFFC);
    step();
    check("s1_instr", 32'(bus_a.instr), 32'h1234);
    check("s1_pc", 32'(bus_a.instr_pc), 32'h0000);
    check("s1_valid", 32'(bus_a.instr_valid), 32'd1);
    check("b_pc0", 32'(bus_b.instr_pc), 32'hFFFC);
    step();
    check("s2_instr", 32'(bus_a.instr), 32'h5678);
    check("s2_pc", 32'(bus_a.instr_pc), 32'h0002);
    check("s2_halted", 32'(bus_a.halted), 32'd0);
    check("b_pc1", 32'(bus_b.instr_pc), 32'hFFFE);
    step();
    check("s3_instr", 32'(bus_a.instr), 32'hF000);
    check("s3_pc", 32'(bus_a.instr_pc), 32'h0004);
    check("s3_halted", 32'(bus_a.halted), 32'd1);
    check("s3_mem_enable", 32'(bus_a.mem_enable), 32'd0);
    check("b_pc2", 32'(bus_b.instr_pc), 32'h0000);
    step();
    check("b_pc3", 32'(bus_b.instr_pc), 32'h0002);
    check("s4_valid", 32'(bus_a.instr_valid), 32'd0);
    issues = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus_a.mem_enable) issues++;
      step();
    end
    check("halt_no_issue", 32'(issues), 32'd0);

    // Stalled decode: exactly DEPTH issues, head stays at the addr-0 word.
    bus_a.instr_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    issues = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus_a.mem_enable) issues++;
      step();
    end
    check("stall_issues", 32'(issues), 32'd2);
    check("stall_mem_enable", 32'(bus_a.mem_enable), 32'd0);
    check("stall_instr", 32'(bus_a.instr), 32'h1234);
    check("stall_pc", 32'(bus_a.instr_pc), 32'h0000);
    bus_a.instr_ready = 1'b1;
    #1;
    check("release_issue", 32'(bus_a.mem_enable), 32'd1);
    check("release_addr", 32'(bus_a.mem_addr), 32'h0004);
    step();
    check("rel1_instr", 32'(bus_a.instr), 32'h5678);
    check("rel1_pc", 32'(bus_a.instr_pc), 32'h0002);
    step();
    check("rel2_instr", 32'(bus_a.instr), 32'hF000);
    check("rel2_pc", 32'(bus_a.instr_pc), 32'h0004);
    step();
    check("rel3_valid", 32'(bus_a.instr_valid), 32'd0);

    // Redirect to an odd target while the queue is full.
    bus_a.instr_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    step();
    check("full_valid", 32'(bus_a.instr_valid), 32'd1);
    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_pc    = 16'h0041;
    #1;
    check("redir_no_issue", 32'(bus_a.mem_enable), 32'd0);
    step();
    bus_a.redirect_valid = 1'b0;
    #1;
    check("redir_valid", 32'(bus_a.instr_valid), 32'd0);
    check("redir_addr", 32'(bus_a.mem_addr), 32'h0040);
    check("redir_enable", 32'(bus_a.mem_enable), 32'd1);
    step();
    check("redir_pc", 32'(bus_a.instr_pc), 32'h0040);
    check("redir_instr", 32'(bus_a.instr), 32'h2222);
    step();

    // Reset with two entries queued.
    rst = 1'b1;
    #1;
    check("midrst_enable", 32'(bus_a.mem_enable), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(bus_a.instr_valid), 32'd0);
    check("midrst_halted", 32'(bus_a.halted), 32'd0);
    check("midrst_addr", 32'(bus_a.mem_addr), 32'h0000);
    step();
    check("midrst_pc", 32'(bus_a.instr_pc), 32'h0000);
    check("midrst_instr", 32'(bus_a.instr), 32'h1234);

`ifdef FETCH_PERF_EN
    // Three fetches then four stall cycles; HLT removed so the unit keeps running.
    mem[2] = 16'h4444;
    rst = 1'b1;
    bus_a.instr_ready = 1'b1;
    step();
    check("perf_rst_fetch", 32'(fc_a), 32'd0);
    rst = 1'b0;
    step();
    step();
    bus_a.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("perf_fetch", 32'(fc_a), 32'd3);
    check("perf_stall", 32'(sc_a), 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
